muldiv_sequencer: RTL and testbench

Multi-cycle HI/LO unit controller for the static pipeline CPU. It accepts the one-hot decoded multiply/divide/HI-LO instructions in EX and sequences a 32-iteration shift-add multiplier or restoring divider. It owns the HI and LO registers and asserts a pipeline stall when a later instruction needs HI/LO or the unit while an operation is in flight. Independent instructions keep flowing while a multiply/divide runs.

---
 rtl/muldiv_sequencer_if.sv | 33 +++
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// HI/LO unit port bundle: decoded EX instruction and operands in, HI/LO state and
// pipeline control out.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic             op_div;
    logic             op_divu;
    logic             op_multu;
    logic             op_mthi;
    logic             op_mtlo;
    logic             op_mfhi;
    logic             op_mflo;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output op_valid, op_div, op_divu, op_multu, op_mthi, op_mtlo, op_mfhi, op_mflo,
        output rs_data, rt_data,
        input  busy, stall, hi, lo, mf_data
    );

    modport slave (
        input  op_valid, op_div, op_divu, op_multu, op_mthi, op_mtlo, op_mfhi, op_mflo,
        input  rs_data, rt_data,
        output busy, stall, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit: 32-step shift-add MULTU and restoring DIV/DIVU,
// owns HI/LO and stalls dependent instructions while an operation runs.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             sdiv_q, sdiv_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             start, hilo_use;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [AW-1:0]    mul_step, div_step;

    assign start    = bus.op_valid & (bus.op_div | bus.op_divu | bus.op_multu);
    assign hilo_use = bus.op_valid & (bus.op_mthi | bus.op_mtlo | bus.op_mfhi | bus.op_mflo);

    assign bus.stall   = busy_q & (start | hilo_use);
    assign bus.busy    = busy_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = bus.op_mfhi ? hi_q : (bus.op_mflo ? lo_q : '0);

    // Magnitudes are only taken for signed DIV; DIVU keeps raw operands.
    assign rs_abs = (bus.op_div && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign rt_abs = (bus.op_div && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient shift register}.
    assign div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_step  = (div_shift >= {1'b0, opb_q})
                     ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                     : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sdiv_d  = sdiv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    if (bus.op_div || bus.op_divu) begin
                        if (bus.rt_data == '0) begin
                            hi_d = bus.rs_data;
                            lo_d = '1;
                        end else begin
                            state_d = S_DIV;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            opb_d   = rt_abs;
                            acc_d   = {WIDTH'(0), rs_abs};
                            sdiv_d  = bus.op_div;
                            qneg_d  = bus.op_div & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                            rneg_d  = bus.op_div & bus.rs_data[WIDTH-1];
                        end
                    end else if (bus.op_multu) begin
                        state_d = S_MUL;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        opb_d   = bus.rs_data;
                        acc_d   = {WIDTH'(0), bus.rt_data};
                        sdiv_d  = 1'b0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end else if (bus.op_mthi) begin
                        hi_d = bus.rs_data;
                    end else if (bus.op_mtlo) begin
                        lo_d = bus.rs_data;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    hi_d    = mul_step[AW-1:WIDTH];
                    lo_d    = mul_step[WIDTH-1:0];
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sdiv_q) begin
                        state_d = S_FIX;
                    end else begin
                        hi_d    = div_step[AW-1:WIDTH];
                        lo_d    = div_step[WIDTH-1:0];
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_FIX: begin
                lo_d    = qneg_q ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
                hi_d    = rneg_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sdiv_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sdiv_q  <= sdiv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected completions and
// MF reads, a monitor checks them as the DUT presents them.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();
    muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [6:0] DIV   = 7'b1000000;
    localparam logic [6:0] DIVU  = 7'b0100000;
    localparam logic [6:0] MULTU = 7'b0010000;
    localparam logic [6:0] MTHI  = 7'b0001000;
    localparam logic [6:0] MTLO  = 7'b0000100;
    localparam logic [6:0] MFHI  = 7'b0000010;
    localparam logic [6:0] MFLO  = 7'b0000001;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } res_t;
    typedef struct {
        string       name;
        logic [31:0] val;
    } mf_t;

    res_t res_q[$];
    mf_t  mf_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [6:0] ops);
        {bus.op_div, bus.op_divu, bus.op_multu, bus.op_mthi,
         bus.op_mtlo, bus.op_mfhi, bus.op_mflo} = ops;
    endtask

    // Present one instruction until it is consumed (stall low), then check stall count.
    task automatic issue(input string name, input logic [6:0] ops, input logic [31:0] rs,
                         input logic [31:0] rt, input int exp_stall);
        int stalls;
        stalls = 0;
        set_ops(ops);
        bus.op_valid = 1'b1;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        @(negedge clk);
        while (bus.stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        set_ops(7'b0);
        check({name, " stalls"}, 32'(stalls), 32'(exp_stall));
    endtask

    task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo,
                              input int cyc);
        res_t r;
        r.name = name; r.hi = hi; r.lo = lo; r.cyc = cyc;
        res_q.push_back(r);
    endtask

    task automatic mf(input string name, input logic [6:0] ops, input logic [31:0] val,
                      input int exp_stall);
        mf_t m;
        m.name = name; m.val = val;
        mf_q.push_back(m);
        issue(name, ops, 32'h0, 32'h0, exp_stall);
    endtask

    // Monitor: busy falling marks a completion (or abort); an unstalled MF is a read.
    initial begin : monitor
        logic busy_prev;
        int   bcnt;
        res_t r;
        mf_t  m;
        busy_prev = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) bcnt++;
            if (busy_prev && bus.busy === 1'b0) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_completion: got hi=%h lo=%h expected none", bus.hi, bus.lo);
                end else begin
                    r = res_q.pop_front();
                    check({r.name, " hi"}, bus.hi, r.hi);
                    check({r.name, " lo"}, bus.lo, r.lo);
                    check({r.name, " busy_cycles"}, 32'(bcnt), 32'(r.cyc));
                end
                bcnt = 0;
            end
            busy_prev = (bus.busy === 1'b1);
            if (bus.op_valid && (bus.op_mfhi || bus.op_mflo) && bus.stall === 1'b0) begin
                if (mf_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_mf: got %h expected none", bus.mf_data);
                end else begin
                    m = mf_q.pop_front();
                    check({m.name, " mf_data"}, bus.mf_data, m.val);
                end
            end
        end
    end

    initial begin : driver
        bus.op_valid = 1'b0;
        set_ops(7'b0);
        bus.rs_data = '0;
        bus.rt_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset stall", 32'(bus.stall), 32'h0);
        check("reset mf_data", bus.mf_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Largest unsigned product
        expect_res("multu_max", 32'hFFFFFFFE, 32'h00000001, 32);
        issue("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        mf("mfhi_max", MFHI, 32'hFFFFFFFE, 32);
        mf("mflo_max", MFLO, 32'h00000001, 0);

        // Signed divides back to back, including the overflow wrap
        expect_res("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        issue("div_m7_2", DIV, 32'hFFFFFFF9, 32'h00000002, 0);
        expect_res("div_ovf", 32'h00000000, 32'h80000000, 33);
        issue("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 33);
        mf("mfhi_ovf", MFHI, 32'h00000000, 33);
        mf("mflo_ovf", MFLO, 32'h80000000, 0);

        expect_res("divu_100_7", 32'd2, 32'd14, 32);
        issue("divu_100_7", DIVU, 32'd100, 32'd7, 0);
        mf("mflo_100_7", MFLO, 32'd14, 32);
        mf("mfhi_100_7", MFHI, 32'd2, 0);

        // Divide by zero completes at the accepting edge without busy
        issue("divu_by0", DIVU, 32'd5, 32'd0, 0);
        @(negedge clk);
        check("divu_by0 busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        mf("mflo_by0", MFLO, 32'hFFFFFFFF, 0);
        mf("mfhi_by0", MFHI, 32'd5, 0);

        // Dependent MFLO stalls for the whole multiply
        expect_res("multu_3_4", 32'd0, 32'd12, 32);
        issue("multu_3_4", MULTU, 32'd3, 32'd4, 0);
        mf("mflo_3_4", MFLO, 32'd12, 32);

        // Second start stalls, then issues with no dead cycle
        expect_res("multu_7_6", 32'd0, 32'd42, 32);
        issue("multu_7_6", MULTU, 32'd7, 32'd6, 0);
        expect_res("multu_2p32", 32'd1, 32'd0, 32);
        issue("multu_2p32", MULTU, 32'h00010000, 32'h00010000, 32);
        mf("mfhi_2p32", MFHI, 32'd1, 32);
        mf("mflo_2p32", MFLO, 32'd0, 0);

        issue("mthi_idle", MTHI, 32'h12345678, 32'h0, 0);
        mf("mfhi_mt", MFHI, 32'h12345678, 0);

        // MTLO behind a multiply lands after the result
        expect_res("multu_2_3", 32'd0, 32'd6, 32);
        issue("multu_2_3", MULTU, 32'd2, 32'd3, 0);
        issue("mtlo_busy", MTLO, 32'hCAFEF00D, 32'h0, 32);
        mf("mflo_mt", MFLO, 32'hCAFEF00D, 0);
        mf("mfhi_after_mt", MFHI, 32'd0, 0);

        // Reset in the 10th busy cycle aborts with hi/lo cleared
        expect_res("multu_abort", 32'd0, 32'd0, 10);
        issue("multu_abort", MULTU, 32'd5, 32'd5, 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_res("divu_9_2", 32'd1, 32'd4, 32);
        issue("divu_9_2", DIVU, 32'd9, 32'd2, 0);
        mf("mflo_9_2", MFLO, 32'd4, 32);

        repeat (5) @(negedge clk);
        check("res_q drained", 32'(res_q.size()), 32'h0);
        check("mf_q drained", 32'(mf_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
